// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter for NUM_REQ lanes sharing one multiplier/memory port.
// Issues a registered one-hot grant that is held until it is accepted through a
// valid/ready handshake. The rotating priority pointer is advanced past each
// accepted winner, and a saturating counter tracks accepted grants.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   req           per-lane request; a lane holds it high until its ack
//   grant_onehot  registered one-hot grant; zero whenever grant_valid is low
//   grant_valid   grant_onehot carries a winner
//   grant_ready   downstream accepts the current grant this cycle
//   ack           combinational per-lane accept pulse (grant & valid & ready)
//   grant_cnt     accepted-grant count, saturating at all-ones
//   cnt_clear     synchronous clear of grant_cnt; takes priority over increment
module rr_grant_arbiter #(
  parameter int unsigned NUM_REQ   = 50,
  parameter int unsigned PTR_WIDTH = 6,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant_onehot,
  output logic                 grant_valid,
  input  logic                 grant_ready,
  output logic [NUM_REQ-1:0]   ack,
  output logic [CNT_WIDTH-1:0] grant_cnt,
  input  logic                 cnt_clear
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic [PTR_WIDTH-1:0] idx_q, idx_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 accept;
  logic [PTR_WIDTH-1:0] ptr_after;
  logic [PTR_WIDTH:0]   pick;

  // Returns {found, index} of the first set bit scanning p..NUM_REQ-1, then 0..p-1.
  // The descending loop lets the lowest index win within each half.
  function automatic logic [PTR_WIDTH:0] rr_pick(input logic [NUM_REQ-1:0]   r,
                                                 input logic [PTR_WIDTH-1:0] p);
    logic                 hi_found;
    logic                 lo_found;
    logic [PTR_WIDTH-1:0] hi_win;
    logic [PTR_WIDTH-1:0] lo_win;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (r[j]) begin
        lo_found = 1'b1;
        lo_win   = PTR_WIDTH'(j);
        if (PTR_WIDTH'(j) >= p) begin
          hi_found = 1'b1;
          hi_win   = PTR_WIDTH'(j);
        end
      end
    end
    return {lo_found, (hi_found ? hi_win : lo_win)};
  endfunction

  assign grant_valid  = (state_q == GRANT);
  assign grant_onehot = grant_q;
  assign grant_cnt    = cnt_q;
  assign accept       = grant_valid & grant_ready;
  assign ack          = grant_q & {NUM_REQ{accept}};

  // Pointer moves to the lane just past the current winner, wrapping at NUM_REQ-1.
  assign ptr_after = (idx_q == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : idx_q + PTR_WIDTH'(1);

  // Next-state: arbitration, back-to-back reload on accept, counter update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    pick    = '0;

    case (state_q)
      IDLE: begin
        pick = rr_pick(req, ptr_q);
        if (pick[PTR_WIDTH]) begin
          idx_d   = pick[PTR_WIDTH-1:0];
          grant_d = NUM_REQ'(1) << pick[PTR_WIDTH-1:0];
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          ptr_d = ptr_after;
          // The served lane is masked so its re-request only counts next cycle.
          pick  = rr_pick(req & ~grant_q, ptr_after);
          if (pick[PTR_WIDTH]) begin
            idx_d   = pick[PTR_WIDTH-1:0];
            grant_d = NUM_REQ'(1) << pick[PTR_WIDTH-1:0];
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase

    if (cnt_clear) begin
      cnt_d = '0;
    end else if (accept && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that picks one of NUM_REQ requesters (SpMV row lanes contending for a shared multiplier/memory port) and issues a registered one-hot grant.
- The one-hot grant feeds the one-hot-to-binary encoder directly downstream, which produces the lane index for the shared datapath.
- Grants are held stable under a valid/ready handshake.
- Per-lane acks and a saturating accepted-grant counter are provided.

Parameters:
- NUM_REQ, 50, number of requesters; one-hot grant width (must be ≥2).
- PTR_WIDTH, 6, width of the internal priority pointer; must satisfy 2^PTR_WIDTH ≥ NUM_REQ.
- CNT_WIDTH, 16, width of the accepted-grant statistics counter.

Ports:
- clk  input  1  single clock; all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-lane request; the lane holds it high until its ack.
- grant_onehot  output  NUM_REQ  registered one-hot grant; all zero when grant_valid=0.
- grant_valid  output  1  grant_onehot holds a valid winner.
- grant_ready  input  1  downstream accepts the current grant this cycle.
- ack  output  NUM_REQ  combinational: grant_onehot AND (grant_valid AND grant_ready).
- grant_cnt  output  CNT_WIDTH  count of accepted grants, saturating at all-ones.
- cnt_clear  input  1  synchronous clear of grant_cnt.

Behaviour:
- Reset (async assert, sync-safe deassert): ptr=0, grant_onehot=0, grant_valid=0, grant_cnt=0, state=IDLE.
- Arbitration function: winner = first set bit of req scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1. Bits ≥ NUM_REQ do not exist.
- States:
  - IDLE: grant_valid=0.
    - If |req=1, register the winner's one-hot and go to GRANT.
    - Latency from req rising to grant_valid is 1 cycle.
  - GRANT: grant_valid=1; grant_onehot is held constant while grant_ready=0.
    - The grant is never retracted, even if the granted lane drops req. That is a protocol violation, flagged by assertion only.
    - On accept (grant_valid and grant_ready): ack pulses for the winner, ptr <= winner+1, wrapping from NUM_REQ-1 to 0.
    - Same accept cycle, next-winner selection:
      - Mask the current winner out of the sampled req.
      - Arbitrate the remainder starting from the new ptr.
      - If any remain, load the new grant and stay in GRANT. Grants run back-to-back with no bubble.
      - Otherwise clear grant_onehot and go to IDLE.
    - A re-request by the just-served lane is seen one cycle later, at lowest priority.
- Fairness: with all lanes requesting continuously and grant_ready=1, the grant rotates strictly 0,1,…,NUM_REQ-1,0,… and a lane waits at most NUM_REQ-1 accepts.
- Counter:
  - grant_cnt += 1 on each accept, saturating at 2^CNT_WIDTH-1.
  - cnt_clear has priority over increment; clear and accept in the same cycle gives 0.
- Invariants (must be bench assertions):
  - grant_onehot is zero or exactly one-hot.
  - Nonzero if and only if grant_valid.
  - Stable while grant_valid and !grant_ready.
  - ack is at most one-hot.
- Reset mid-GRANT: outputs go to zero immediately (async); no ack is issued for the in-flight grant.

Test Plan:
1. NUM_REQ=4, req=4'b0100 from reset, grant_ready=1 → cycle+1: grant_onehot=0100, valid=1, ack=0100; next cycle valid=0, ptr=3.
2. req=4'b1111 held, grant_ready=1 for 8 cycles → grants 0001,0010,0100,1000,0001,… with no bubble; grant_cnt=8.
3. req=4'b0011, grant_ready=0 for 5 cycles then 1 → grant_onehot=0001 stable for 5 cycles, then ack=0001; the next cycle grant=0010.
4. ptr=3 (after serving lane 2), req=4'b0101 → lane 0 wins via wrap-around (0001), then lane 2.
5. CNT_WIDTH=2, 5 accepts → grant_cnt 1,2,3,3,3. Then cnt_clear in the same cycle as an accept → 0.
6. rst_n pulsed low while grant_valid=1 and grant_ready=0 → outputs 0 immediately, no ack; after release, arbitration restarts with ptr=0.
